// File: rtl/chacha_sched.sv
// Round-robin scheduler sharing one ChaCha core among NUM_REQ requesters.
// Optional WAIT-state watchdog is built only when CHACHA_SCHED_WDOG_EN is defined.

module chacha_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int NBLK_W      = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [255:0]              key,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*64-1:0]     req_iv,
  input  logic [NUM_REQ*64-1:0]     req_ctr,
  input  logic [NUM_REQ*NBLK_W-1:0] req_nblk,
  input  logic [NUM_REQ-1:0]        blk_valid,
  output logic [NUM_REQ-1:0]        blk_ready,
  input  logic [NUM_REQ*512-1:0]    blk_data,
  output logic                      core_init,
  output logic                      core_next,
  output logic [63:0]               core_ctr,
  output logic [63:0]               core_iv,
  output logic [255:0]              core_key,
  output logic [511:0]              core_data,
  input  logic                      core_ready,
  input  logic                      core_valid,
  input  logic [511:0]              core_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [511:0]              out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int SW = ID_W + 1;

  state_t            state, next_state;
  logic [ID_W-1:0]   ptr, owner, grant;
  logic              grant_found;
  logic [SW-1:0]     cand;
  logic [NBLK_W-1:0] sel_nblk, nblk_r, idx;
  logic [63:0]       iv_r, ctr0_r;
  logic [255:0]      key_r;
  logic              last_blk;
  logic              wdog_expire;

  // First valid requester at or after ptr, searching upward with wrap.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + SW'(i);
      if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant       = cand[ID_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  assign sel_nblk  = req_nblk[NBLK_W*grant +: NBLK_W];
  assign last_blk  = (idx == nblk_r - NBLK_W'(1));

  assign req_ready = (state == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant) : '0;
  assign blk_ready = (state == S_FETCH) ? (NUM_REQ'(1) << owner) : '0;
  assign core_init = (state == S_ISSUE) && core_ready && (idx == '0);
  assign core_next = (state == S_ISSUE) && core_ready && (idx != '0);
  assign core_ctr  = ctr0_r + 64'(idx);
  assign core_iv   = iv_r;
  assign core_key  = key_r;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant_found && sel_nblk != '0) next_state = S_FETCH;
      S_FETCH: if (blk_valid[owner]) next_state = S_ISSUE;
      S_ISSUE: if (core_ready) next_state = S_WAIT;
      S_WAIT: begin
        if (core_valid)       next_state = S_OUT;
        else if (wdog_expire) next_state = S_IDLE;
      end
      S_OUT:   if (out_ready) next_state = last_blk ? S_IDLE : S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  // Job context is captured at grant, even for empty jobs, so ptr always advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      iv_r      <= '0;
      ctr0_r    <= '0;
      nblk_r    <= '0;
      key_r     <= '0;
      idx       <= '0;
      core_data <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        owner  <= grant;
        iv_r   <= req_iv[64*grant +: 64];
        ctr0_r <= req_ctr[64*grant +: 64];
        nblk_r <= sel_nblk;
        key_r  <= key;
        idx    <= '0;
        ptr    <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
      if (state == S_FETCH && blk_valid[owner])
        core_data <= blk_data[512*owner +: 512];
      if (state == S_WAIT && core_valid) begin
        out_valid <= 1'b1;
        out_data  <= core_out;
        out_id    <= owner;
        out_last  <= last_blk;
      end
      if (state == S_OUT && out_ready) begin
        out_valid <= 1'b0;
        idx       <= idx + NBLK_W'(1);
      end
    end
  end

`ifdef CHACHA_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;

  assign wdog_expire = (state == S_WAIT) && !core_valid &&
                       (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  // Counter restarts every time WAIT is entered; err is a single-cycle abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= wdog_expire;
      if (state != S_WAIT)  wdog_cnt <= '0;
      else if (!core_valid) wdog_cnt <= wdog_cnt + WD_W'(1);
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign wdog_expire     = 1'b0;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_sched.sv
// Scoreboard bench for chacha_sched: directed jobs, a 1-cycle-latency core model,
// and a negedge monitor that checks grants, core issues and results against queues.

module tb_chacha_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int NBLK_W  = 16;
  localparam int WDOG    = 8;

  typedef struct packed {
    logic [511:0]    data;
    logic [ID_W-1:0] id;
    logic            last;
  } out_t;

  typedef struct packed {
    logic        init;
    logic [63:0] ctr;
  } iss_t;

  logic clk = 1'b0;
  logic rst;
  logic [255:0]              key = 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_00112233_44556677_8899AABB_CCDDEEFF;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*64-1:0]     req_iv;
  logic [NUM_REQ*64-1:0]     req_ctr;
  logic [NUM_REQ*NBLK_W-1:0] req_nblk;
  logic [NUM_REQ-1:0]        blk_valid;
  logic [NUM_REQ-1:0]        blk_ready;
  logic [NUM_REQ*512-1:0]    blk_data;
  logic                      core_init, core_next;
  logic [63:0]               core_ctr, core_iv;
  logic [255:0]              core_key;
  logic [511:0]              core_data;
  logic                      core_ready;
  logic                      core_valid;
  logic [511:0]              core_out;
  logic                      out_valid, out_ready;
  logic [511:0]              out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_last, busy, err;

  always #5 clk = ~clk;

  chacha_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .NBLK_W(NBLK_W), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .req_valid(req_valid), .req_ready(req_ready), .req_iv(req_iv),
    .req_ctr(req_ctr), .req_nblk(req_nblk),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .core_init(core_init), .core_next(core_next), .core_ctr(core_ctr),
    .core_iv(core_iv), .core_key(core_key), .core_data(core_data),
    .core_ready(core_ready), .core_valid(core_valid), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy), .err(err)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   grantsSeen = 0;
  int   expGrant[$];
  iss_t expIss[$];
  out_t expOut[$];
  int   monGrant;
  int   curOwner = 0;
  iss_t monIss;
  out_t monOut;

  logic         fireN = 1'b0;
  logic [511:0] fireD = '0;
  logic         stageV = 1'b0;
  logic [511:0] stageD = '0;
  logic         coreMute = 1'b0;

  // Stand-in keystream: any fixed function of key/iv/ctr exposes routing errors.
  function automatic logic [511:0] ks(input logic [255:0] k, input logic [63:0] iv,
                                      input logic [63:0] c);
    logic [511:0] r;
    for (int j = 0; j < 8; j++)
      r[64*j +: 64] = k[64*(j%4) +: 64] ^ iv ^ (c + 64'(j)) ^ {c[31:0], iv[63:32]};
    return r;
  endfunction

  function automatic logic [511:0] pattern(input int r);
    return {8{64'h1111_2222_3333_0000 + 64'(r * 17)}} ^ {64'(r), 448'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectJob(input int r, input logic [63:0] iv, input logic [63:0] c0,
                           input logic [NBLK_W-1:0] nblk);
    expGrant.push_back(r);
    for (int k = 0; k < int'(nblk); k++) begin
      expIss.push_back('{init: (k == 0), ctr: c0 + 64'(k)});
      expOut.push_back('{data: pattern(r) ^ ks(key, iv, c0 + 64'(k)),
                         id: ID_W'(r), last: (k == int'(nblk) - 1)});
    end
  endtask

  task automatic waitGrants(input int target);
    int n = 0;
    while (grantsSeen < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (grantsSeen < target) checkOutput("grant_wait", 512'(grantsSeen), 512'(target));
  endtask

  task automatic applyStimulus(input int r, input logic [63:0] iv, input logic [63:0] c0,
                               input logic [NBLK_W-1:0] nblk);
    int target;
    expectJob(r, iv, c0, nblk);
    req_iv[64*r +: 64]           = iv;
    req_ctr[64*r +: 64]          = c0;
    req_nblk[NBLK_W*r +: NBLK_W] = nblk;
    target       = grantsSeen + 1;
    req_valid[r] = 1'b1;
    waitGrants(target);
    req_valid[r] = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || expOut.size() != 0 || expIss.size() != 0) && n < 300);
    if (n >= 300) begin
      checkOutput("idle_busy", 512'(busy), 512'(0));
      checkOutput("pending_outputs", 512'(expOut.size()), 512'(0));
    end
  endtask

  task automatic waitInit();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_init && n < 50);
    if (!core_init) checkOutput("init_wait", 512'(core_init), 512'(1));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    expGrant.delete();
    expIss.delete();
    expOut.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 512'(req_ready), 512'(0));
    checkOutput({tag, "_blk_ready"}, 512'(blk_ready), 512'(0));
    checkOutput({tag, "_flags"}, 512'({core_init, core_next, out_valid, out_last, busy, err}), 512'(0));
    checkOutput({tag, "_core_ctr_iv"}, 512'({core_ctr, core_iv}), 512'(0));
    checkOutput({tag, "_core_key"}, 512'(core_key), 512'(0));
    checkOutput({tag, "_core_data"}, core_data, 512'(0));
    checkOutput({tag, "_out_data_id"}, out_data ^ 512'(out_id), 512'(0));
  endtask

  // Core model: result appears one cycle after the issue cycle ends.
  always @(posedge clk) begin
    #1;
    core_valid = stageV;
    core_out   = stageD;
    stageV     = fireN;
    stageD     = fireD;
  end

  // Monitor: every grant, issue and result is popped from its queue and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) begin
        grantsSeen++;
        if (expGrant.size() == 0) checkOutput("grant_unexpected", 512'(req_ready), 512'(0));
        else begin
          monGrant = expGrant.pop_front();
          curOwner = monGrant;
          checkOutput("grant", 512'(req_ready), 512'(4'b0001 << monGrant));
        end
      end
      if (|blk_ready) checkOutput("blk_ready_owner", 512'(blk_ready), 512'(4'b0001 << curOwner));
      if (core_ready && (core_init || core_next)) begin
        if (expIss.size() == 0) checkOutput("issue_unexpected", 512'({core_init, core_next}), 512'(0));
        else begin
          monIss = expIss.pop_front();
          checkOutput("issue_kind", 512'({core_init, core_next}), 512'({monIss.init, ~monIss.init}));
          checkOutput("issue_ctr", 512'(core_ctr), 512'(monIss.ctr));
        end
      end
      if (out_valid && out_ready) begin
        if (expOut.size() == 0) checkOutput("out_unexpected", 512'(out_valid), 512'(0));
        else begin
          monOut = expOut.pop_front();
          checkOutput("out_data", out_data, monOut.data);
          checkOutput("out_id_last", 512'({out_id, out_last}), 512'({monOut.id, monOut.last}));
        end
      end
    end
    fireN = core_ready && (core_init || core_next) && !coreMute;
    fireD = core_data ^ ks(core_key, core_iv, core_ctr);
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_iv     = '0;
    req_ctr    = '0;
    req_nblk   = '0;
    blk_valid  = '1;
    out_ready  = 1'b1;
    core_ready = 1'b1;
    core_valid = 1'b0;
    core_out   = '0;
    for (int r = 0; r < NUM_REQ; r++) blk_data[512*r +: 512] = pattern(r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single job, three blocks");
    applyStimulus(0, 64'h0123_4567_89AB_CDEF, 64'd5, 16'd3);
    waitIdle();

    $display("[TB] fairness, all four requesters");
    pulseReset();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_iv[64*r +: 64]           = 64'hA5A5_0000_0000_0000 + 64'(r);
      req_ctr[64*r +: 64]          = 64'd1000 + 64'(r * 10);
      req_nblk[NBLK_W*r +: NBLK_W] = 16'd1;
    end
    for (int j = 0; j < 5; j++)
      expectJob(j % 4, 64'hA5A5_0000_0000_0000 + 64'(j % 4), 64'd1000 + 64'((j % 4) * 10), 16'd1);
    req_valid = 4'b1111;
    waitGrants(grantsSeen + 5);
    req_valid = '0;
    waitIdle();

    $display("[TB] fairness, requester 2 idle");
    pulseReset();
    expectJob(0, 64'hA5A5_0000_0000_0000, 64'd1000, 16'd1);
    expectJob(1, 64'hA5A5_0000_0000_0001, 64'd1010, 16'd1);
    expectJob(3, 64'hA5A5_0000_0000_0003, 64'd1030, 16'd1);
    expectJob(0, 64'hA5A5_0000_0000_0000, 64'd1000, 16'd1);
    req_valid = 4'b1011;
    waitGrants(grantsSeen + 4);
    req_valid = '0;
    waitIdle();

    $display("[TB] output backpressure");
    out_ready = 1'b0;
    applyStimulus(1, 64'hDEAD_BEEF_0000_0001, 64'd100, 16'd2);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      checkOutput("bp_out_data", out_data, pattern(1) ^ ks(key, 64'hDEAD_BEEF_0000_0001, 64'd100));
      checkOutput("bp_out_flags", 512'({out_valid, out_id, out_last}), 512'({1'b1, 2'd1, 1'b0}));
      checkOutput("bp_blk_ready", 512'(blk_ready), 512'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] counter wrap");
    applyStimulus(3, 64'h0000_1111_2222_3333, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
    waitIdle();

    $display("[TB] empty job");
    applyStimulus(2, 64'h7777_0000_0000_0002, 64'd9, 16'd0);
    @(negedge clk);
    checkOutput("empty_busy", 512'(busy), 512'(0));
    waitIdle();

    $display("[TB] reset during WAIT");
    applyStimulus(2, 64'h5555_AAAA_5555_AAAA, 64'd50, 16'd3);
    waitInit();
    pulseReset();
    @(negedge clk);
    checkIdleOutputs("midwait");
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("stray_out_valid", 512'({out_valid, busy}), 512'(0));
    end

    $display("[TB] silent core");
    coreMute = 1'b1;
    applyStimulus(1, 64'h9999_0000_0000_0001, 64'd7, 16'd2);
    waitInit();
`ifdef CHACHA_SCHED_WDOG_EN
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      checkOutput("wdog_err", 512'(err), 512'(n == 9));
      checkOutput("wdog_busy_out", 512'({busy, out_valid}), 512'({(n < 9), 1'b0}));
    end
`else
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checkOutput("nowdog_err", 512'(err), 512'(0));
      checkOutput("nowdog_busy_out", 512'({busy, out_valid}), 512'({1'b1, 1'b0}));
    end
`endif
    pulseReset();
    coreMute = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
